// File: rtl/lc3_mem_port.sv
// LC-3 MAR/MDR memory port: latches address/data and runs req/ack memory transactions, stalling the controller.
// Optional feature: define MEM_TIMEOUT_EN to abort transactions that are not acknowledged within TIMEOUT_CYCLES.
module lc3_mem_port #(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ldMAR,
  input  logic              ldMDR,
  input  logic              selMDR,
  input  logic              enaMDR,
  input  logic              memWE,
  input  logic [DATA_W-1:0] busIn,
  output logic [DATA_W-1:0] busOut,
  output logic              busOutEn,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  if (TIMEOUT_CYCLES == 0) begin : g_timeout_chk
    $error("TIMEOUT_CYCLES must be non-zero");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              mem_we_q, mem_we_d;
  logic              bus_err_q, bus_err_d;
  // Set when an access finishes; blocks restarts until the command level drops.
  logic              cmd_done_q, cmd_done_d;

  logic rd_cmd;
  logic wr_cmd;
  logic bus_load;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(16'hDEAD);
  logic [TMR_W-1:0] timer_q, timer_d;
`endif

  assign rd_cmd   = ldMDR & selMDR;
  assign wr_cmd   = memWE;
  assign bus_load = ldMAR | (ldMDR & ~selMDR);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mar_q      <= '0;
      mdr_q      <= '0;
      mem_we_q   <= 1'b0;
      bus_err_q  <= 1'b0;
      cmd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
      mem_we_q   <= mem_we_d;
      bus_err_q  <= bus_err_d;
      cmd_done_q <= cmd_done_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  // Next-state, datapath updates and stall
  always_comb begin
    state_d    = state_q;
    mar_d      = mar_q;
    mdr_d      = mdr_q;
    mem_we_d   = mem_we_q;
    bus_err_d  = bus_err_q;
    cmd_done_d = cmd_done_q;
    stall      = 1'b0;
`ifdef MEM_TIMEOUT_EN
    timer_d    = timer_q;
`endif

    case (state_q)
      IDLE: begin
        if ((rd_cmd || wr_cmd) && !cmd_done_q) begin
          // Start an access; MAR/MDR stay frozen from this edge on.
          stall    = 1'b1;
          state_d  = REQ;
          mem_we_d = ~rd_cmd;
          if (rd_cmd && wr_cmd) begin
            bus_err_d = 1'b1;
          end
`ifdef MEM_TIMEOUT_EN
          timer_d  = '0;
`endif
        end else begin
          if (!(rd_cmd || wr_cmd)) begin
            cmd_done_d = 1'b0;
          end
          if (ldMAR) begin
            mar_d = ADDR_W'(busIn);
          end
          if (ldMDR && !selMDR) begin
            mdr_d = busIn;
          end
        end
      end

      REQ: begin
        if (bus_load) begin
          bus_err_d = 1'b1;
        end
        if (mem_ack) begin
          if (!mem_we_q) begin
            mdr_d = mem_rdata;
          end
          state_d    = IDLE;
          cmd_done_d = 1'b1;
        end else begin
`ifdef MEM_TIMEOUT_EN
          if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            // Abort: release the controller and flag the failure.
            if (!mem_we_q) begin
              mdr_d = ABORT_DATA;
            end
            bus_err_d  = 1'b1;
            state_d    = IDLE;
            cmd_done_d = 1'b1;
          end else begin
            stall   = 1'b1;
            timer_d = timer_q + TMR_W'(1);
          end
`else
          stall = 1'b1;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_req   = (state_q == REQ);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign bus_err   = bus_err_q;
  assign busOut    = enaMDR ? mdr_q : '0;
  assign busOutEn  = enaMDR;

endmodule
